scpu_mem_arbiter: RTL and testbench

//  Shares one single-ported synchronous RAM between three requesters: CPU data port (D),

---
 rtl/scpu_mem_arbiter_pkg.sv | 21 ++
 rtl/scpu_mem_arbiter_if.sv | 39 +++
 rtl/scpu_mem_arbiter_sel.sv | 30 +++
 rtl/scpu_mem_arbiter.sv | 121 ++++++++++++
 tb/tb_scpu_mem_arbiter.sv | 358 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/scpu_mem_arbiter_pkg.sv
// Shared types for the SCPU memory arbiter: FSM states, owner IDs, counter widths.
package scpu_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    OWN_D = 2'd0,
    OWN_G = 2'd1,
    OWN_I = 2'd2
  } owner_e;

  // MEM_LAT is at most 7, STARVE_MAX at most 15
  localparam int LAT_W = 3;
  localparam int AGE_W = 4;

endpackage

// File: rtl/scpu_mem_arbiter_if.sv
// Requester ports (D, G, I), RAM port and busy flag of the SCPU memory arbiter.
interface scpu_mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              d_req, d_we, d_ack;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata, d_rdata;
  logic              g_req, g_we, g_ack;
  logic [ADDR_W-1:0] g_addr;
  logic [DATA_W-1:0] g_wdata, g_rdata;
  logic              i_req, i_ack;
  logic [ADDR_W-1:0] i_addr;
  logic [DATA_W-1:0] i_rdata;
  logic              mem_en, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;
  logic              busy;

  // arbiter side
  modport slave (
    input  d_req, d_we, d_addr, d_wdata,
    input  g_req, g_we, g_addr, g_wdata,
    input  i_req, i_addr,
    input  mem_rdata,
    output d_ack, d_rdata, g_ack, g_rdata, i_ack, i_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata, busy
  );

  // requesters + RAM side
  modport master (
    output d_req, d_we, d_addr, d_wdata,
    output g_req, g_we, g_addr, g_wdata,
    output i_req, i_addr,
    output mem_rdata,
    input  d_ack, d_rdata, g_ack, g_rdata, i_ack, i_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata, busy
  );
endinterface

// File: rtl/scpu_mem_arbiter_sel.sv
// Combinational 3-way priority picker: D > G > I, or I first when promoted.
module scpu_arb_select
  import scpu_mem_arbiter_pkg::*;
(
  input  logic [2:0] req_i,      // {i, g, d}
  input  logic       promote_i,
  output logic [2:0] gnt_o,      // one-hot {i, g, d}
  output owner_e     own_o
);

  // promotion only matters when I is actually asking
  always_comb begin
    gnt_o = 3'b000;
    own_o = OWN_D;
    if (promote_i && req_i[2]) begin
      gnt_o = 3'b100;
      own_o = OWN_I;
    end else if (req_i[0]) begin
      gnt_o = 3'b001;
      own_o = OWN_D;
    end else if (req_i[1]) begin
      gnt_o = 3'b010;
      own_o = OWN_G;
    end else if (req_i[2]) begin
      gnt_o = 3'b100;
      own_o = OWN_I;
    end
  end

endmodule

// File: rtl/scpu_mem_arbiter.sv
// Serialises D/G/I accesses onto one synchronous RAM with read-latency tracking
// and an aging counter that bounds instruction-fetch starvation.
module scpu_mem_arbiter
  import scpu_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  scpu_mem_arbiter_if.slave bus
);

  localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(MEM_LAT);
  localparam logic [AGE_W-1:0] AGE_MAX  = AGE_W'(STARVE_MAX);

  state_e            state_q, state_d;
  owner_e            own_q, own_win;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [LAT_W-1:0]  lat_q;
  logic [AGE_W-1:0]  age_q;
  logic [DATA_W-1:0] d_rdata_q, g_rdata_q, i_rdata_q;
  logic [2:0]        req, gnt;
  logic              promote, grant_now, rd_done;

  assign req       = {bus.i_req, bus.g_req, bus.d_req};
  assign promote   = (age_q == AGE_MAX);
  assign grant_now = (state_q == ST_IDLE) && (|req);
  // RAM data is valid in the last WAIT cycle
  assign rd_done   = (state_q == ST_WAIT) && (lat_q == LAT_W'(1));

  scpu_arb_select u_sel (
    .req_i     (req),
    .promote_i (promote),
    .gnt_o     (gnt),
    .own_o     (own_win)
  );

  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // next-state: IDLE -> ISSUE -> (WAIT)* -> RESP -> IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (|req) state_d = ST_ISSUE;
      ST_ISSUE: state_d = we_q ? ST_RESP : ST_WAIT;
      ST_WAIT:  if (lat_q == LAT_W'(1)) state_d = ST_RESP;
      ST_RESP:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // latch the winner's request at grant; later input changes are ignored
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      own_q   <= OWN_D;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      lat_q   <= '0;
    end else begin
      if (grant_now) begin
        own_q   <= own_win;
        we_q    <= (gnt[0] & bus.d_we) | (gnt[1] & bus.g_we);
        addr_q  <= gnt[0] ? bus.d_addr  : (gnt[1] ? bus.g_addr  : bus.i_addr);
        wdata_q <= gnt[0] ? bus.d_wdata : (gnt[1] ? bus.g_wdata : '0);
      end
      if (state_q == ST_ISSUE)     lat_q <= LAT_INIT;
      else if (state_q == ST_WAIT) lat_q <= lat_q - LAT_W'(1);
    end
  end

  // aging: count grants that pass over a waiting I, clear when I wins
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      age_q <= '0;
    end else if (grant_now) begin
      if (gnt[2])                            age_q <= '0;
      else if (bus.i_req && age_q < AGE_MAX) age_q <= age_q + AGE_W'(1);
    end
  end

  // read data lands only in the owner's register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      d_rdata_q <= '0;
      g_rdata_q <= '0;
      i_rdata_q <= '0;
    end else if (rd_done) begin
      case (own_q)
        OWN_D:   d_rdata_q <= bus.mem_rdata;
        OWN_G:   g_rdata_q <= bus.mem_rdata;
        default: i_rdata_q <= bus.mem_rdata;
      endcase
    end
  end

  // outputs decoded from registered state only
  always_comb begin
    bus.mem_en    = (state_q == ST_ISSUE);
    bus.mem_we    = (state_q == ST_ISSUE) && we_q;
    bus.mem_addr  = addr_q;
    bus.mem_wdata = wdata_q;
    bus.busy      = (state_q != ST_IDLE);
    bus.d_ack     = (state_q == ST_RESP) && (own_q == OWN_D);
    bus.g_ack     = (state_q == ST_RESP) && (own_q == OWN_G);
    bus.i_ack     = (state_q == ST_RESP) && (own_q == OWN_I);
    bus.d_rdata   = d_rdata_q;
    bus.g_rdata   = g_rdata_q;
    bus.i_rdata   = i_rdata_q;
  end

endmodule

// File: tb/tb_scpu_mem_arbiter.sv
// Bench for scpu_mem_arbiter: directed scenarios on a MEM_LAT=1 and a MEM_LAT=3
// instance, then randomized traffic against a transaction-level reference model.
module tb_scpu_mem_arbiter;
  localparam int L0 = 1;
  localparam int L1 = 3;
  localparam int SMAX = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic preload = 1'b1;
  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] mdl [256];

  always #5 clk = ~clk;

  scpu_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus0 ();
  scpu_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus1 ();

  scpu_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(L0), .STARVE_MAX(SMAX)) u0 (
    .clk(clk), .rst(rst), .bus(bus0.slave));
  scpu_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(L1), .STARVE_MAX(SMAX)) u1 (
    .clk(clk), .rst(rst), .bus(bus1.slave));

  function automatic logic [31:0] init_word(input int k);
    return 32'hC0DE_0000 | (32'(k & 255) * 32'h0000_0101);
  endfunction

  // RAM for u0: data valid one cycle after the strobe, poisoned otherwise
  logic [31:0] ram0 [256];
  logic [31:0] rp0;
  logic        rv0;
  always @(posedge clk) begin
    rv0 <= 1'b0;
    if (preload) begin
      for (int k = 0; k < 256; k++) ram0[k] <= init_word(k);
    end else if (bus0.mem_en) begin
      if (bus0.mem_we) ram0[bus0.mem_addr[7:0]] <= bus0.mem_wdata;
      else begin
        rp0 <= ram0[bus0.mem_addr[7:0]];
        rv0 <= 1'b1;
      end
    end
  end
  assign bus0.mem_rdata = rv0 ? rp0 : 32'hBAD0_BAD0;

  // RAM for u1: three-cycle read pipeline
  logic [31:0] ram1 [256];
  logic [31:0] rp1 [3];
  logic [2:0]  rv1;
  logic        rd1;
  assign rd1 = bus1.mem_en && !bus1.mem_we && !preload;
  always @(posedge clk) begin
    rv1    <= {rv1[1:0], rd1};
    rp1[1] <= rp1[0];
    rp1[2] <= rp1[1];
    if (preload) begin
      for (int k = 0; k < 256; k++) ram1[k] <= init_word(k);
    end else if (bus1.mem_en) begin
      if (bus1.mem_we) ram1[bus1.mem_addr[7:0]] <= bus1.mem_wdata;
      else             rp1[0] <= ram1[bus1.mem_addr[7:0]];
    end
  end
  assign bus1.mem_rdata = rv1[2] ? rp1[2] : 32'hBAD1_BAD1;

  task automatic set_req(input int p, input logic r, input logic we,
                         input logic [31:0] a, input logic [31:0] wd);
    case (p)
      0: begin bus0.d_req = r; bus0.d_we = we; bus0.d_addr = a; bus0.d_wdata = wd; end
      1: begin bus0.g_req = r; bus0.g_we = we; bus0.g_addr = a; bus0.g_wdata = wd; end
      default: begin bus0.i_req = r; bus0.i_addr = a; end
    endcase
  endtask

  function automatic logic ack_of(input int p);
    case (p)
      0: return bus0.d_ack;
      1: return bus0.g_ack;
      default: return bus0.i_ack;
    endcase
  endfunction

  function automatic logic [31:0] rdata_of(input int p);
    case (p)
      0: return bus0.d_rdata;
      1: return bus0.g_rdata;
      default: return bus0.i_rdata;
    endcase
  endfunction

  // one transaction on u0; request raised in the current (IDLE) cycle = cycle 0
  task automatic run_req(input int p, input logic we, input logic [31:0] a, input logic [31:0] wd,
                         output int en_c, output int ack_c, output logic [31:0] rd);
    en_c = -1; ack_c = -1; rd = '0;
    set_req(p, 1'b1, we, a, wd);
    for (int k = 1; k <= 30 && ack_c < 0; k++) begin
      @(negedge clk);
      if (bus0.mem_en && en_c < 0) en_c = k;
      if (ack_of(p)) begin ack_c = k; rd = rdata_of(p); end
    end
    set_req(p, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0; preload = 1'b1;
    bus0.d_req = 1; bus0.d_we = 1; bus0.d_addr = 32'h11; bus0.d_wdata = 32'h1;
    bus0.g_req = 1; bus0.g_we = 0; bus0.g_addr = 32'h12; bus0.g_wdata = 32'h2;
    bus0.i_req = 1; bus0.i_addr = 32'h13;
    bus1.d_req = 1; bus1.d_we = 0; bus1.d_addr = 32'h21; bus1.d_wdata = 32'h3;
    bus1.g_req = 1; bus1.g_we = 1; bus1.g_addr = 32'h22; bus1.g_wdata = 32'h4;
    bus1.i_req = 1; bus1.i_addr = 32'h23;
    for (int k = 0; k < 256; k++) mdl[k] = init_word(k);
    repeat (5) begin
      @(negedge clk);
      n_cmp++;
      if ({bus0.mem_en, bus0.mem_we, bus0.d_ack, bus0.g_ack, bus0.i_ack, bus0.busy} !== 6'b0) begin
        n_bad++; $display("FAIL reset_ctl0: got %b want 000000",
          {bus0.mem_en, bus0.mem_we, bus0.d_ack, bus0.g_ack, bus0.i_ack, bus0.busy});
      end
      n_cmp++;
      if ({bus0.mem_addr, bus0.mem_wdata, bus0.d_rdata, bus0.g_rdata, bus0.i_rdata} !== 160'b0) begin
        n_bad++; $display("FAIL reset_data0: got %h want 0",
          {bus0.mem_addr, bus0.mem_wdata, bus0.d_rdata, bus0.g_rdata, bus0.i_rdata});
      end
      n_cmp++;
      if ({bus1.mem_en, bus1.d_ack, bus1.g_ack, bus1.i_ack, bus1.busy} !== 5'b0) begin
        n_bad++; $display("FAIL reset_ctl1: got %b want 00000",
          {bus1.mem_en, bus1.d_ack, bus1.g_ack, bus1.i_ack, bus1.busy});
      end
    end
    bus0.d_req = 0; bus0.g_req = 0; bus0.i_req = 0;
    bus1.d_req = 0; bus1.g_req = 0; bus1.i_req = 0;
    bus1.d_we = 0; bus1.g_we = 0;
    preload = 1'b0;
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    int en_c, ack_c; logic [31:0] rd;
    run_req(1, 1'b1, 32'h10, 32'hDEAD_BEEF, en_c, ack_c, rd);
    mdl[16] = 32'hDEAD_BEEF;
    n_cmp++; if (en_c !== 1) begin n_bad++; $display("FAIL wr_en_cycle: got %0d want 1", en_c); end
    n_cmp++; if (ack_c !== 2) begin n_bad++; $display("FAIL wr_ack_cycle: got %0d want 2", ack_c); end
    n_cmp++; if (ram0[16] !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL wr_ram: got %h want deadbeef", ram0[16]); end
    n_cmp++; if (bus0.g_rdata !== 32'h0) begin n_bad++; $display("FAIL wr_rdata_hold: got %h want 0", bus0.g_rdata); end
    run_req(0, 1'b0, 32'h10, 32'h0, en_c, ack_c, rd);
    n_cmp++; if (en_c !== 1) begin n_bad++; $display("FAIL rd_en_cycle: got %0d want 1", en_c); end
    n_cmp++; if (ack_c !== 2 + L0) begin n_bad++; $display("FAIL rd_ack_cycle: got %0d want %0d", ack_c, 2 + L0); end
    n_cmp++; if (rd !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL rd_data: got %h want deadbeef", rd); end
    run_req(2, 1'b0, 32'h22, 32'h0, en_c, ack_c, rd);
    n_cmp++; if (ack_c !== 2 + L0) begin n_bad++; $display("FAIL i_ack_cycle: got %0d want %0d", ack_c, 2 + L0); end
    n_cmp++; if (rd !== mdl[8'h22]) begin n_bad++; $display("FAIL i_rd_data: got %h want %h", rd, mdl[8'h22]); end
  endtask

  task automatic test_dg();
    int en_c, ack_c, dc, gc; logic [31:0] rd;
    run_req(1, 1'b0, 32'h20, 32'h0, en_c, ack_c, rd);
    n_cmp++; if (rd !== mdl[8'h20]) begin n_bad++; $display("FAIL dg_pre: got %h want %h", rd, mdl[8'h20]); end
    dc = -1; gc = -1;
    set_req(0, 1'b1, 1'b0, 32'h30, 32'h0);
    set_req(1, 1'b1, 1'b0, 32'h40, 32'h0);
    for (int k = 1; k <= 40 && (dc < 0 || gc < 0); k++) begin
      @(negedge clk);
      if (bus0.d_ack) begin
        dc = k;
        n_cmp++; if (bus0.d_rdata !== mdl[8'h30]) begin n_bad++; $display("FAIL dg_d_data: got %h want %h", bus0.d_rdata, mdl[8'h30]); end
        n_cmp++; if (bus0.g_rdata !== mdl[8'h20]) begin n_bad++; $display("FAIL dg_g_hold: got %h want %h", bus0.g_rdata, mdl[8'h20]); end
        set_req(0, 1'b0, 1'b0, '0, '0);
      end
      if (bus0.g_ack) begin
        gc = k;
        n_cmp++; if (bus0.g_rdata !== mdl[8'h40]) begin n_bad++; $display("FAIL dg_g_data: got %h want %h", bus0.g_rdata, mdl[8'h40]); end
        set_req(1, 1'b0, 1'b0, '0, '0);
      end
    end
    set_req(0, 1'b0, 1'b0, '0, '0); set_req(1, 1'b0, 1'b0, '0, '0);
    n_cmp++; if (dc !== 2 + L0) begin n_bad++; $display("FAIL dg_d_cycle: got %0d want %0d", dc, 2 + L0); end
    n_cmp++; if (gc !== 2 * (3 + L0) - 1) begin n_bad++; $display("FAIL dg_g_cycle: got %0d want %0d", gc, 2 * (3 + L0) - 1); end
    @(negedge clk);
  endtask

  // D and I both held high continuously: I should win every (SMAX+1)th grant
  task automatic test_starve();
    int seq [10]; int n;
    n = 0;
    for (int k = 0; k < 10; k++) seq[k] = -1;
    set_req(0, 1'b1, 1'b0, 32'h05, 32'h0);
    set_req(2, 1'b1, 1'b0, 32'h06, 32'h0);
    for (int k = 0; k < 200 && n < 10; k++) begin
      @(negedge clk);
      if (bus0.d_ack) begin seq[n] = 0; n++; end
      else if (bus0.g_ack) begin seq[n] = 1; n++; end
      else if (bus0.i_ack) begin seq[n] = 2; n++; end
    end
    set_req(0, 1'b0, 1'b0, '0, '0); set_req(2, 1'b0, 1'b0, '0, '0);
    for (int k = 0; k < 10; k++) begin
      n_cmp++;
      if (seq[k] !== ((k % (SMAX + 1) == SMAX) ? 2 : 0)) begin
        n_bad++; $display("FAIL starve_order[%0d]: got %0d want %0d", k, seq[k], (k % (SMAX + 1) == SMAX) ? 2 : 0);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_lat3();
    int en_c, ack_c; logic [31:0] ea, rd; logic ew;
    en_c = -1; ack_c = -1; ea = '0; rd = '0; ew = 1'bx;
    bus1.d_req = 1; bus1.d_we = 0; bus1.d_addr = 32'h33; bus1.d_wdata = 32'h0;
    for (int k = 1; k <= 20 && ack_c < 0; k++) begin
      @(negedge clk);
      if (k == 1) begin bus1.d_addr = 32'h77; bus1.d_we = 1; bus1.d_wdata = 32'h5555_AAAA; end
      if (bus1.mem_en && en_c < 0) begin en_c = k; ea = bus1.mem_addr; ew = bus1.mem_we; end
      if (bus1.d_ack) begin ack_c = k; rd = bus1.d_rdata; bus1.d_req = 0; end
    end
    bus1.d_req = 0; bus1.d_we = 0;
    n_cmp++; if (en_c !== 1) begin n_bad++; $display("FAIL lat3_en_cycle: got %0d want 1", en_c); end
    n_cmp++; if ({ew, ea} !== {1'b0, 32'h33}) begin n_bad++; $display("FAIL lat3_latched: got %b/%h want 0/00000033", ew, ea); end
    n_cmp++; if (ack_c !== 2 + L1) begin n_bad++; $display("FAIL lat3_ack_cycle: got %0d want %0d", ack_c, 2 + L1); end
    n_cmp++; if (rd !== init_word(8'h33)) begin n_bad++; $display("FAIL lat3_data: got %h want %h", rd, init_word(8'h33)); end
    @(negedge clk);
    ack_c = -1;
    bus1.g_req = 1; bus1.g_we = 1; bus1.g_addr = 32'h44; bus1.g_wdata = 32'h1234_5678;
    for (int k = 1; k <= 20 && ack_c < 0; k++) begin
      @(negedge clk);
      if (bus1.g_ack) begin ack_c = k; bus1.g_req = 0; end
    end
    bus1.g_req = 0; bus1.g_we = 0;
    n_cmp++; if (ack_c !== 2) begin n_bad++; $display("FAIL lat3_wr_cycle: got %0d want 2", ack_c); end
    n_cmp++; if (ram1[8'h44] !== 32'h1234_5678) begin n_bad++; $display("FAIL lat3_wr_ram: got %h want 12345678", ram1[8'h44]); end
    @(negedge clk);
  endtask

  task automatic test_reset_wait();
    int en_c, ack_c, seen; logic [31:0] rd;
    seen = 0;
    set_req(0, 1'b1, 1'b0, 32'h50, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_cmp++; if ({bus0.busy, bus0.d_ack} !== 2'b00) begin n_bad++; $display("FAIL rstw_abort: got %b want 00", {bus0.busy, bus0.d_ack}); end
    set_req(0, 1'b0, 1'b0, '0, '0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (bus0.d_ack || bus0.g_ack || bus0.i_ack || bus0.mem_en) seen++;
    end
    n_cmp++; if (seen !== 0) begin n_bad++; $display("FAIL rstw_quiet: got %0d strobe/ack cycles want 0", seen); end
    n_cmp++; if (bus0.d_rdata !== 32'h0) begin n_bad++; $display("FAIL rstw_rdata: got %h want 0", bus0.d_rdata); end
    run_req(0, 1'b0, 32'h51, 32'h0, en_c, ack_c, rd);
    n_cmp++; if (ack_c !== 2 + L0) begin n_bad++; $display("FAIL rstw_next_cycle: got %0d want %0d", ack_c, 2 + L0); end
    n_cmp++; if (rd !== mdl[8'h51]) begin n_bad++; $display("FAIL rstw_next_data: got %h want %h", rd, mdl[8'h51]); end
  endtask

  // Random traffic; the model plans each transaction from the arbitration
  // rules and fixed latencies, then checks every cycle against that plan.
  task automatic test_random();
    int free_at, iss_at, ack_at, own, age, win;
    logic granted, x_we;
    logic [31:0] x_addr, x_wd, x_rd;
    logic [31:0] hold [3];
    logic pend [3]; logic just [3]; logic we_v [3];
    logic [31:0] ad_v [3]; logic [31:0] wd_v [3];
    logic [2:0] exp_ack;
    free_at = 0; iss_at = -1; ack_at = -1; own = 0; age = 0; win = 0;
    granted = 0; x_we = 0; x_addr = 0; x_wd = 0; x_rd = 0;
    for (int p = 0; p < 3; p++) begin
      hold[p] = '0; pend[p] = 0; just[p] = 0; we_v[p] = 0; ad_v[p] = '0; wd_v[p] = '0;
      set_req(p, 1'b0, 1'b0, '0, '0);
    end
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(negedge clk);
      n_cmp++;
      if (bus0.mem_en !== (granted && cyc == iss_at)) begin
        n_bad++; $display("FAIL rnd_mem_en cyc=%0d: got %b want %b", cyc, bus0.mem_en, granted && cyc == iss_at);
      end
      if (granted && cyc == iss_at) begin
        n_cmp++;
        if ({bus0.mem_we, bus0.mem_addr} !== {x_we, x_addr}) begin
          n_bad++; $display("FAIL rnd_mem_cmd cyc=%0d: got %b/%h want %b/%h", cyc, bus0.mem_we, bus0.mem_addr, x_we, x_addr);
        end
        if (x_we) begin
          n_cmp++;
          if (bus0.mem_wdata !== x_wd) begin n_bad++; $display("FAIL rnd_mem_wdata cyc=%0d: got %h want %h", cyc, bus0.mem_wdata, x_wd); end
        end
      end
      n_cmp++;
      if (bus0.busy !== (granted && cyc >= iss_at && cyc <= ack_at)) begin
        n_bad++; $display("FAIL rnd_busy cyc=%0d: got %b want %b", cyc, bus0.busy, granted && cyc >= iss_at && cyc <= ack_at);
      end
      exp_ack = (granted && cyc == ack_at) ? (3'b001 << own) : 3'b000;
      n_cmp++;
      if ({bus0.i_ack, bus0.g_ack, bus0.d_ack} !== exp_ack) begin
        n_bad++; $display("FAIL rnd_ack cyc=%0d: got %b want %b", cyc, {bus0.i_ack, bus0.g_ack, bus0.d_ack}, exp_ack);
      end
      for (int p = 0; p < 3; p++) just[p] = 0;
      if (granted && cyc == ack_at) begin
        if (!x_we) hold[own] = x_rd;
        n_cmp++;
        if ({bus0.d_rdata, bus0.g_rdata, bus0.i_rdata} !== {hold[0], hold[1], hold[2]}) begin
          n_bad++; $display("FAIL rnd_rdata cyc=%0d: got %h/%h/%h want %h/%h/%h", cyc,
            bus0.d_rdata, bus0.g_rdata, bus0.i_rdata, hold[0], hold[1], hold[2]);
        end
        pend[own] = 0; just[own] = 1;
        set_req(own, 1'b0, 1'b0, '0, '0);
        granted = 0;
      end
      // requesters: raise new requests, or wiggle fields of pending ones
      for (int p = 0; p < 3; p++) begin
        if ((!pend[p] && !just[p] && $urandom_range(0, 2) == 0) ||
            (pend[p] && $urandom_range(0, 3) == 0)) begin
          pend[p] = 1;
          we_v[p] = (p != 2) && ($urandom_range(0, 1) == 1);
          ad_v[p] = $urandom;
          wd_v[p] = $urandom;
          set_req(p, 1'b1, we_v[p], ad_v[p], wd_v[p]);
        end
      end
      // grant decision for the cycle whose closing edge samples these requests
      if (!granted && cyc >= free_at && (pend[0] || pend[1] || pend[2])) begin
        if (age == SMAX && pend[2]) win = 2;
        else if (pend[0])           win = 0;
        else if (pend[1])           win = 1;
        else                        win = 2;
        if (win == 2)     age = 0;
        else if (pend[2]) age = (age < SMAX) ? age + 1 : age;
        own = win; x_we = we_v[win]; x_addr = ad_v[win]; x_wd = wd_v[win];
        if (x_we) mdl[x_addr[7:0]] = x_wd;
        else      x_rd = mdl[x_addr[7:0]];
        iss_at = cyc + 1;
        ack_at = cyc + 2 + (x_we ? 0 : L0);
        free_at = ack_at + 1;
        granted = 1;
      end
    end
    for (int p = 0; p < 3; p++) set_req(p, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single();
    test_dg();
    test_starve();
    test_lat3();
    test_reset_wait();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
